// File: rtl/milano_pkg.sv
// milano_pkg: shared types for the milano execute stage.
//   alu_opt_e  - ALU operation select, including the divider operations
//   ex_state_e - execute-stage sequencing state (IDLE / BUSY)
// Helper functions classify the divider operations.
package milano_pkg;

    typedef enum logic [3:0] {
        ALU_NONE = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10,
        ALU_DIV  = 4'd11,
        ALU_DIVU = 4'd12,
        ALU_REM  = 4'd13,
        ALU_REMU = 4'd14
    } alu_opt_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ex_state_e;

    function automatic logic is_div_op(alu_opt_e op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic is_signed_div(alu_opt_e op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic is_rem_op(alu_opt_e op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/milano_div.sv
// milano_div: iterative restoring divider, one quotient bit per cycle.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   start_i         load operands and begin a DATA_W-cycle divide
//   kill_i          abort a divide in progress (no result)
//   signed_i        operands are two's complement
//   rem_i           return remainder instead of quotient
//   a_i, b_i        dividend, divisor
//   special_o       divide-by-zero or signed overflow: result available now
//   busy_o          divide in progress
//   done_o          final iteration this cycle; result_o holds the sign-fixed result
//   result_o        final result when done_o, otherwise the special-case result
module milano_div #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              kill_i,
    input  logic              signed_i,
    input  logic              rem_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              special_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int CW = $clog2(DATA_W);

    logic              busy_q, busy_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] quo_q, quo_d;   // dividend shifts out MSB-first, quotient shifts in
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic              rem_op_q, rem_op_d;
    logic              neg_q, neg_d;

    logic              a_neg, b_neg, div_zero, sgn_ovf, last, qbit;
    logic [DATA_W-1:0] a_mag, b_mag, spec_res, rem_nxt, quo_nxt, raw, fixed;
    logic [DATA_W:0]   shifted, diff;

    always_comb begin
        a_neg    = signed_i & a_i[DATA_W-1];
        b_neg    = signed_i & b_i[DATA_W-1];
        a_mag    = a_neg ? -a_i : a_i;
        b_mag    = b_neg ? -b_i : b_i;
        div_zero = (b_i == '0);
        sgn_ovf  = signed_i && (a_i == {1'b1, {(DATA_W-1){1'b0}}}) && (b_i == '1);
        special_o = div_zero || sgn_ovf;
        if (div_zero) spec_res = rem_i ? a_i : '1;
        else          spec_res = rem_i ? '0  : a_i;
    end

    // Restoring step: the partial remainder never exceeds 2*divisor, so one extra bit suffices.
    always_comb begin
        shifted = {rem_q, quo_q[DATA_W-1]};
        diff    = shifted - {1'b0, dvs_q};
        qbit    = ~diff[DATA_W];
        rem_nxt = qbit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_nxt = {quo_q[DATA_W-2:0], qbit};
        last    = (cnt_q == CW'(DATA_W-1));
        done_o  = busy_q && last && !kill_i;
        busy_o  = busy_q;
        raw     = rem_op_q ? rem_nxt : quo_nxt;
        fixed   = neg_q ? -raw : raw;
        result_o = done_o ? fixed : spec_res;
    end

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        rem_op_d = rem_op_q;
        neg_d    = neg_q;
        if (kill_i) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            quo_d = quo_nxt;
            rem_d = rem_nxt;
            cnt_d = cnt_q + CW'(1);
            if (last) busy_d = 1'b0;
        end else if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            quo_d    = a_mag;
            rem_d    = '0;
            dvs_d    = b_mag;
            rem_op_d = rem_i;
            // remainder follows the dividend sign, quotient the sign product
            neg_d    = rem_i ? a_neg : (a_neg ^ b_neg);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            rem_op_q <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            rem_op_q <= rem_op_d;
            neg_q    <= neg_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: milano execute stage, between the ID/EX and EX/MEM registers.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   valid_i, alu_operate_i        live instruction and its operation
//   rs1_data_i, rs2_data_i        operands
//   rd_addr_i, rd_wr_en_i         destination control
//   flush_i                       kill the accepted / in-flight instruction
//   stall_o                       ID/EX must hold (combinational)
//   valid_o, rd_addr_o, rd_wr_en_o, rd_data_o   registered result bundle
// Build option: define MILANO_DIV_EN to include the iterative divider.
// Without it DIV/DIVU/REM/REMU complete in one cycle like ALU_NONE.
module ex_stage
    import milano_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  alu_opt_e          alu_operate_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              rd_wr_en_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [4:0]        rd_addr_o,
    output logic              rd_wr_en_o,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int SHW = $clog2(DATA_W);

    logic              valid_q, valid_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic              rd_wr_en_q, rd_wr_en_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              op_is_div, acc_1c, div_fin, fin_wr_en, alu_wr;
    logic [4:0]        fin_addr;
    logic [DATA_W-1:0] alu_res, fin_data;
    logic [SHW-1:0]    shamt;

    assign op_is_div = is_div_op(alu_operate_i);
    assign shamt     = rs2_data_i[SHW-1:0];

`ifdef MILANO_DIV_EN
    ex_state_e         state_q, state_d;
    logic [4:0]        div_rd_addr_q, div_rd_addr_d;
    logic              div_rd_wr_en_q, div_rd_wr_en_d;
    logic              take, div_wait, div_start, div_special, div_busy, div_done;
    logic [DATA_W-1:0] div_result;

    milano_div #(.DATA_W(DATA_W)) u_div (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .start_i   (div_start),
        .kill_i    (flush_i),
        .signed_i  (is_signed_div(alu_operate_i)),
        .rem_i     (is_rem_op(alu_operate_i)),
        .a_i       (rs1_data_i),
        .b_i       (rs2_data_i),
        .special_o (div_special),
        .busy_o    (div_busy),
        .done_o    (div_done),
        .result_o  (div_result)
    );

    always_comb begin
        // A flush while BUSY only aborts the divide; the stage is free again this
        // cycle, so the presented instruction is taken. A flush in IDLE drops it.
        take      = valid_i && ((state_q == IDLE) ? !flush_i : flush_i);
        div_wait  = take && op_is_div && !div_special;
        stall_o   = (div_busy && !flush_i) || div_wait;
        // a divide presented during an abort waits one cycle and starts from IDLE
        div_start = div_wait && (state_q == IDLE);
        acc_1c    = take && !div_wait;
        div_fin   = div_done;
        fin_addr  = div_rd_addr_q;
        fin_wr_en = div_rd_wr_en_q;
        fin_data  = div_result;
        alu_wr    = rd_wr_en_i && (alu_operate_i != ALU_NONE);

        state_d = state_q;
        if (state_q == IDLE) begin
            if (div_start) state_d = BUSY;
        end else if (flush_i || div_done) begin
            state_d = IDLE;
        end

        div_rd_addr_d  = div_start ? rd_addr_i  : div_rd_addr_q;
        div_rd_wr_en_d = div_start ? rd_wr_en_i : div_rd_wr_en_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            div_rd_addr_q  <= '0;
            div_rd_wr_en_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            div_rd_addr_q  <= div_rd_addr_d;
            div_rd_wr_en_q <= div_rd_wr_en_d;
        end
    end
`else
    always_comb begin
        stall_o   = 1'b0;
        acc_1c    = valid_i && !flush_i;
        div_fin   = 1'b0;
        fin_addr  = '0;
        fin_wr_en = 1'b0;
        fin_data  = '0;
        alu_wr    = rd_wr_en_i && (alu_operate_i != ALU_NONE) && !op_is_div;
    end
`endif

    always_comb begin
        alu_res = '0;
        case (alu_operate_i)
            ALU_ADD:  alu_res = rs1_data_i + rs2_data_i;
            ALU_SUB:  alu_res = rs1_data_i - rs2_data_i;
            ALU_AND:  alu_res = rs1_data_i & rs2_data_i;
            ALU_OR:   alu_res = rs1_data_i | rs2_data_i;
            ALU_XOR:  alu_res = rs1_data_i ^ rs2_data_i;
            ALU_SLL:  alu_res = rs1_data_i << shamt;
            ALU_SRL:  alu_res = rs1_data_i >> shamt;
            ALU_SRA:  alu_res = DATA_W'($signed(rs1_data_i) >>> shamt);
            ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(rs1_data_i) < $signed(rs2_data_i)};
            ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, rs1_data_i < rs2_data_i};
            default:  alu_res = '0;
        endcase
`ifdef MILANO_DIV_EN
        // only special-case divides complete in one cycle
        if (op_is_div) alu_res = div_result;
`endif
    end

    // rd_data/rd_addr hold through bubbles; valid and write enable drop
    always_comb begin
        valid_d    = 1'b0;
        rd_wr_en_d = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_data_d  = rd_data_q;
        if (acc_1c) begin
            valid_d    = 1'b1;
            rd_addr_d  = rd_addr_i;
            rd_wr_en_d = alu_wr;
            rd_data_d  = alu_res;
        end else if (div_fin) begin
            valid_d    = 1'b1;
            rd_addr_d  = fin_addr;
            rd_wr_en_d = fin_wr_en;
            rd_data_d  = fin_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_wr_en_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            rd_addr_q  <= rd_addr_d;
            rd_wr_en_q <= rd_wr_en_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign valid_o    = valid_q;
    assign rd_addr_o  = rd_addr_q;
    assign rd_wr_en_o = rd_wr_en_q;
    assign rd_data_o  = rd_data_q;

endmodule
